// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst sequencer and its per-side splitter.
package dma_pkg;

    localparam int ADDR_W     = 32;
    localparam int NB_W       = 32;
    localparam int BPB        = 64;
    localparam int BPB_LOG2   = 6;
    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_LOG2  = 12;

    typedef logic [7:0] axi_len_t;

    typedef struct packed {
        logic [ADDR_W-1:0] src_addr;
        logic [ADDR_W-1:0] dst_addr;
        logic [NB_W-1:0]   num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic [BPB_LOG2-1:0] head;
        logic [BPB_LOG2-1:0] tail;
        axi_len_t            alen;
        logic                valid;
    } s_dma_aligner_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } dma_state_e;

endpackage

// File: rtl/dma_burst_splitter.sv
// One side (read or write) of the burst sequencer: walks an address/byte range and
// produces beat-aligned bursts that never cross a 4 KB page or exceed MAX_BEATS.
module dma_burst_splitter
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int BEAT_BYTES = BPB,
    parameter int MAX_BEATS  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear_i,
    input  logic                            load_i,
    input  logic [ADDR_WIDTH-1:0]           addr_i,
    input  logic [NB_W-1:0]                 bytes_i,
    input  logic                            hs_i,
    output logic [ADDR_WIDTH-1:0]           addr_o,
    output axi_len_t                        len_o,
    output logic [$clog2(BEAT_BYTES)-1:0]   head_o,
    output logic [$clog2(BEAT_BYTES)-1:0]   tail_o,
    output logic                            active_o
);

    localparam int OFF_W      = $clog2(BEAT_BYTES);
    localparam int CW         = NB_W + 2;
    localparam int PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, aligned;
    logic [NB_W-1:0]       rem_q, rem_d;
    logic                  first_q, first_d;
    logic [OFF_W-1:0]      off, end_off;
    logic [CW-1:0]         needed, to_page, beats, span, consumed;
    logic                  last;

    always_comb begin
        off      = addr_q[OFF_W-1:0];
        aligned  = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
        needed   = (CW'(off) + CW'(rem_q) + CW'(BEAT_BYTES - 1)) >> OFF_W;
        to_page  = CW'(PAGE_BEATS) - CW'(addr_q[PAGE_LOG2-1:OFF_W]);
        beats    = needed;
        if (to_page < beats)
            beats = to_page;
        if (CW'(MAX_BEATS) < beats)
            beats = CW'(MAX_BEATS);
        // span = payload bytes this burst can carry past the head offset
        span     = (beats << OFF_W) - CW'(off);
        last     = CW'(rem_q) <= span;
        consumed = last ? CW'(rem_q) : span;
        end_off  = off + consumed[OFF_W-1:0];

        active_o = rem_q != '0;
        addr_o   = aligned;
        len_o    = active_o ? axi_len_t'(beats - CW'(1)) : '0;
        head_o   = first_q ? off : '0;
        tail_o   = (active_o && last) ? (OFF_W'(0) - end_off) : '0;

        addr_d   = addr_q;
        rem_d    = rem_q;
        first_d  = first_q;
        if (clear_i) begin
            rem_d   = '0;
            first_d = 1'b0;
        end else if (load_i) begin
            addr_d  = addr_i;
            rem_d   = bytes_i;
            first_d = 1'b1;
        end else if (hs_i) begin
            addr_d  = aligned + ADDR_WIDTH'(beats << OFF_W);
            rem_d   = rem_q - NB_W'(consumed);
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/dma_burst_sequencer.sv
// Splits one DMA descriptor into AXI AR/AW bursts plus aligner requests and tracks B responses.
// Optional burst statistics counters are built when DMA_BURST_STATS_EN is defined.
module dma_burst_sequencer
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_BEATS       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  dma_go_i,
    input  s_dma_desc_t           dma_desc_i,
    output logic                  dma_go_o,
    output s_dma_desc_t           dma_desc_o,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    output axi_len_t              ar_len_o,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [ADDR_WIDTH-1:0] aw_addr_o,
    output axi_len_t              aw_len_o,
    input  logic                  b_valid_i,
    output s_dma_aligner_req_t    src_info_o,
    output s_dma_aligner_req_t    dst_info_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           ar_cnt_o,
    output logic [15:0]           aw_cnt_o
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    dma_state_e        state_q, state_d;
    s_dma_desc_t       desc_q;
    logic              go_q, done_q, done_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              accept, load, ar_hs, aw_hs, b_take;
    logic              rd_active, wr_active;
    logic [BPB_LOG2-1:0] rd_head, rd_tail, wr_head, wr_tail;

    assign accept = (state_q == ST_IDLE) && dma_go_i && !clear_i;
    assign load   = accept && (dma_desc_i.num_bytes != '0);

    assign ar_valid_o = (state_q == ST_RUN) && rd_active;
    assign aw_valid_o = (state_q == ST_RUN) && wr_active && (out_q != OUT_W'(MAX_OUTSTANDING));
    assign ar_hs      = ar_valid_o && ar_ready_i;
    assign aw_hs      = aw_valid_o && aw_ready_i;
    assign b_take     = b_valid_i && (out_q != '0);

    dma_burst_splitter #(
        .ADDR_WIDTH(ADDR_WIDTH), .BEAT_BYTES(BEAT_BYTES), .MAX_BEATS(MAX_BEATS)
    ) u_rd (
        .clk(clk), .rst(rst), .clear_i(clear_i), .load_i(load),
        .addr_i(dma_desc_i.src_addr), .bytes_i(dma_desc_i.num_bytes), .hs_i(ar_hs),
        .addr_o(ar_addr_o), .len_o(ar_len_o), .head_o(rd_head), .tail_o(rd_tail),
        .active_o(rd_active)
    );

    dma_burst_splitter #(
        .ADDR_WIDTH(ADDR_WIDTH), .BEAT_BYTES(BEAT_BYTES), .MAX_BEATS(MAX_BEATS)
    ) u_wr (
        .clk(clk), .rst(rst), .clear_i(clear_i), .load_i(load),
        .addr_i(dma_desc_i.dst_addr), .bytes_i(dma_desc_i.num_bytes), .hs_i(aw_hs),
        .addr_o(aw_addr_o), .len_o(aw_len_o), .head_o(wr_head), .tail_o(wr_tail),
        .active_o(wr_active)
    );

    always_comb begin
        src_info_o = '0;
        dst_info_o = '0;
        if (ar_hs)
            src_info_o = '{head: rd_head, tail: rd_tail, alen: ar_len_o, valid: 1'b1};
        if (aw_hs)
            dst_info_o = '{head: wr_head, tail: wr_tail, alen: aw_len_o, valid: 1'b1};
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        out_d   = out_q;
        if (aw_hs && !b_take)
            out_d = out_q + OUT_W'(1);
        else if (!aw_hs && b_take)
            out_d = out_q - OUT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (dma_go_i) begin
                    if (dma_desc_i.num_bytes != '0)
                        state_d = ST_RUN;
                    else
                        done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!rd_active && !wr_active)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // abort wins over every other event, including a same-cycle completion
        if (clear_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            out_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
            go_q    <= load;
            if (load)
                desc_q <= dma_desc_i;
        end
    end

    assign dma_go_o   = go_q;
    assign dma_desc_o = desc_q;
    assign busy_o     = state_q != ST_IDLE;
    assign done_o     = done_q;

`ifdef DMA_BURST_STATS_EN
    logic [15:0] ar_cnt_q, aw_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_cnt_q <= '0;
            aw_cnt_q <= '0;
        end else if (clear_i || accept) begin
            ar_cnt_q <= '0;
            aw_cnt_q <= '0;
        end else begin
            if (ar_hs && ar_cnt_q != 16'hFFFF)
                ar_cnt_q <= ar_cnt_q + 16'd1;
            if (aw_hs && aw_cnt_q != 16'hFFFF)
                aw_cnt_q <= aw_cnt_q + 16'd1;
        end
    end

    assign ar_cnt_o = ar_cnt_q;
    assign aw_cnt_o = aw_cnt_q;
`else
    assign ar_cnt_o = 16'd0;
    assign aw_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Self-checking bench for dma_burst_sequencer: directed and randomized descriptors
// compared against a byte-range model of the burst split.
module tb_dma_burst_sequencer;
    import dma_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear_i = 1'b0;
    logic               dma_go_i = 1'b0;
    s_dma_desc_t        dma_desc_i = '0;
    logic               dma_go_o;
    s_dma_desc_t        dma_desc_o;
    logic               ar_valid_o, aw_valid_o;
    logic               ar_ready_i = 1'b0, aw_ready_i = 1'b0, b_valid_i = 1'b0;
    logic [31:0]        ar_addr_o, aw_addr_o;
    axi_len_t           ar_len_o, aw_len_o;
    s_dma_aligner_req_t src_info_o, dst_info_o;
    logic               busy_o, done_o;
    logic [15:0]        ar_cnt_o, aw_cnt_o;

    dma_burst_sequencer dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .dma_go_i(dma_go_i), .dma_desc_i(dma_desc_i),
        .dma_go_o(dma_go_o), .dma_desc_o(dma_desc_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
        .b_valid_i(b_valid_i), .src_info_o(src_info_o), .dst_info_o(dst_info_o),
        .busy_o(busy_o), .done_o(done_o), .ar_cnt_o(ar_cnt_o), .aw_cnt_o(aw_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  head;
        logic [5:0]  tail;
        logic [7:0]  alen;
        logic        ivld;
    } burst_t;

    burst_t exp_ar[$], exp_aw[$], obs_ar[$], obs_aw[$];
    int checks = 0, failures = 0;
    int ar_hs_cnt = 0, aw_hs_cnt = 0, done_cnt = 0, go_cnt = 0, pending_b = 0;
    int ready_mode = 0;
    bit b_auto = 1'b0;

    bit          ar_wait_q = 0, aw_wait_q = 0, prev_ctl = 1;
    logic [31:0] ar_a_q, aw_a_q;
    logic [7:0]  ar_l_q, aw_l_q;

    // Observer: collects handshakes, tracks outstanding writes, checks protocol rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (ar_wait_q && !prev_ctl) begin
                checks++;
                if (!(ar_valid_o === 1'b1 && ar_addr_o === ar_a_q && ar_len_o === ar_l_q)) begin
                    failures++;
                    $display("FAIL ar_hold: got v=%0b addr=%h len=%0d, want v=1 addr=%h len=%0d",
                             ar_valid_o, ar_addr_o, ar_len_o, ar_a_q, ar_l_q);
                end
            end
            if (aw_wait_q && !prev_ctl) begin
                checks++;
                if (!(aw_valid_o === 1'b1 && aw_addr_o === aw_a_q && aw_len_o === aw_l_q)) begin
                    failures++;
                    $display("FAIL aw_hold: got v=%0b addr=%h len=%0d, want v=1 addr=%h len=%0d",
                             aw_valid_o, aw_addr_o, aw_len_o, aw_a_q, aw_l_q);
                end
            end
            if (src_info_o.valid !== (ar_valid_o & ar_ready_i)) begin
                checks++; failures++;
                $display("FAIL src_info_valid: got %0b want %0b", src_info_o.valid, ar_valid_o & ar_ready_i);
            end
            if (dst_info_o.valid !== (aw_valid_o & aw_ready_i)) begin
                checks++; failures++;
                $display("FAIL dst_info_valid: got %0b want %0b", dst_info_o.valid, aw_valid_o & aw_ready_i);
            end
            if (ar_valid_o && ar_ready_i) begin
                obs_ar.push_back({ar_addr_o, ar_len_o, src_info_o.head, src_info_o.tail,
                                  src_info_o.alen, src_info_o.valid});
                ar_hs_cnt++;
            end
            if (aw_valid_o && aw_ready_i) begin
                checks++;
                if (pending_b >= 4) begin
                    failures++;
                    $display("FAIL outstanding_limit: AW accepted with %0d outstanding, max 4", pending_b);
                end
                obs_aw.push_back({aw_addr_o, aw_len_o, dst_info_o.head, dst_info_o.tail,
                                  dst_info_o.alen, dst_info_o.valid});
                aw_hs_cnt++;
                pending_b++;
            end
            if (b_valid_i && pending_b > 0)
                pending_b--;
            if (done_o)   done_cnt++;
            if (dma_go_o) go_cnt++;
        end
        ar_wait_q = ar_valid_o && !ar_ready_i;
        aw_wait_q = aw_valid_o && !aw_ready_i;
        ar_a_q = ar_addr_o; ar_l_q = ar_len_o;
        aw_a_q = aw_addr_o; aw_l_q = aw_len_o;
        prev_ctl = clear_i | rst;
    end

    // Slave-side stimulus: ready pattern and B responses for accepted writes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       begin ar_ready_i = 1'b1; aw_ready_i = 1'b1; end
                1:       begin ar_ready_i = 1'($urandom_range(0, 1)); aw_ready_i = 1'($urandom_range(0, 1)); end
                default: begin ar_ready_i = 1'b0; aw_ready_i = 1'b0; end
            endcase
            if (b_auto)
                b_valid_i = (pending_b > 0) && ($urandom_range(0, 2) != 0);
        end
    end

    task automatic reset_obs();
        exp_ar.delete(); exp_aw.delete(); obs_ar.delete(); obs_aw.delete();
        ar_hs_cnt = 0; aw_hs_cnt = 0; done_cnt = 0; go_cnt = 0;
    endtask

    // Byte-range view: each burst ends at the earliest of transfer end, page end, or MAX_BEATS.
    task automatic model_side(input longint a, input longint n, input bit wr);
        longint cur, rem, aligned, page_end, lim, stop, end_b, beats;
        bit first, last;
        burst_t r;
        cur = a; rem = n; first = 1;
        while (rem > 0) begin
            aligned  = cur - (cur % 64);
            page_end = cur - (cur % 4096) + 4096;
            lim      = aligned + 16 * 64;
            if (page_end < lim) lim = page_end;
            stop  = cur + rem;
            last  = (stop <= lim);
            end_b = last ? stop : lim;
            beats = (end_b - aligned + 63) / 64;
            r.addr = 32'(aligned);
            r.len  = 8'(beats - 1);
            r.head = first ? 6'(cur % 64) : 6'd0;
            r.tail = last ? 6'(aligned + beats * 64 - end_b) : 6'd0;
            r.alen = 8'(beats - 1);
            r.ivld = 1'b1;
            if (wr) exp_aw.push_back(r); else exp_ar.push_back(r);
            rem   = rem - (end_b - cur);
            cur   = end_b;
            first = 0;
        end
    endtask

    task automatic start_go(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        @(posedge clk); #1;
        dma_desc_i = '{src_addr: s, dst_addr: d, num_bytes: n};
        dma_go_i = 1'b1;
        @(posedge clk); #1;
        dma_go_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s_done_timeout: no done_o within %0d cycles", name, budget);
        end
    endtask

    task automatic compare_all(input string name);
        int exp_stat_ar, exp_stat_aw;
        checks++;
        if (obs_ar.size() != exp_ar.size()) begin
            failures++;
            $display("FAIL %s_ar_count: got %0d bursts, want %0d", name, obs_ar.size(), exp_ar.size());
        end
        for (int i = 0; i < exp_ar.size() && i < obs_ar.size(); i++) begin
            checks++;
            if (obs_ar[i] !== exp_ar[i]) begin
                failures++;
                $display("FAIL %s_ar[%0d]: got addr=%h len=%0d head=%0d tail=%0d alen=%0d v=%0b, want addr=%h len=%0d head=%0d tail=%0d",
                         name, i, obs_ar[i].addr, obs_ar[i].len, obs_ar[i].head, obs_ar[i].tail, obs_ar[i].alen,
                         obs_ar[i].ivld, exp_ar[i].addr, exp_ar[i].len, exp_ar[i].head, exp_ar[i].tail);
            end
        end
        checks++;
        if (obs_aw.size() != exp_aw.size()) begin
            failures++;
            $display("FAIL %s_aw_count: got %0d bursts, want %0d", name, obs_aw.size(), exp_aw.size());
        end
        for (int i = 0; i < exp_aw.size() && i < obs_aw.size(); i++) begin
            checks++;
            if (obs_aw[i] !== exp_aw[i]) begin
                failures++;
                $display("FAIL %s_aw[%0d]: got addr=%h len=%0d head=%0d tail=%0d alen=%0d v=%0b, want addr=%h len=%0d head=%0d tail=%0d",
                         name, i, obs_aw[i].addr, obs_aw[i].len, obs_aw[i].head, obs_aw[i].tail, obs_aw[i].alen,
                         obs_aw[i].ivld, exp_aw[i].addr, exp_aw[i].len, exp_aw[i].head, exp_aw[i].tail);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s_done_pulses: got %0d, want 1", name, done_cnt);
        end
        checks++;
        if (go_cnt != 1) begin
            failures++;
            $display("FAIL %s_go_pulses: got %0d, want 1", name, go_cnt);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_after_done: got %0b, want 0", name, busy_o);
        end
`ifdef DMA_BURST_STATS_EN
        exp_stat_ar = exp_ar.size(); exp_stat_aw = exp_aw.size();
`else
        exp_stat_ar = 0; exp_stat_aw = 0;
`endif
        checks++;
        if (ar_cnt_o !== 16'(exp_stat_ar) || aw_cnt_o !== 16'(exp_stat_aw)) begin
            failures++;
            $display("FAIL %s_stats: got ar=%0d aw=%0d, want ar=%0d aw=%0d", name, ar_cnt_o, aw_cnt_o,
                     exp_stat_ar, exp_stat_aw);
        end
    endtask

    task automatic run_transfer(input string name, input logic [31:0] s, input logic [31:0] d,
                                input logic [31:0] n, input int rmode);
        reset_obs();
        ready_mode = rmode;
        b_auto = 1'b1;
        model_side(s, n, 0);
        model_side(d, n, 1);
        start_go(s, d, n);
        wait_done(name, 3000);
        repeat (2) @(negedge clk);
        compare_all(name);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (ar_valid_o !== 1'b0 || aw_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_valids: got ar=%0b aw=%0b, want 0 0", ar_valid_o, aw_valid_o);
        end
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || dma_go_o !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl: got busy=%0b done=%0b go=%0b, want 0 0 0", busy_o, done_o, dma_go_o);
        end
        checks++;
        if (ar_addr_o !== 32'd0 || ar_len_o !== 8'd0 || aw_addr_o !== 32'd0 || aw_len_o !== 8'd0) begin
            failures++; $display("FAIL reset_addr_len: got %h/%0d %h/%0d, want zeros", ar_addr_o, ar_len_o, aw_addr_o, aw_len_o);
        end
        checks++;
        if (src_info_o !== '0 || dst_info_o !== '0 || dma_desc_o !== '0) begin
            failures++; $display("FAIL reset_info: got src=%h dst=%h desc=%h, want 0", src_info_o, dst_info_o, dma_desc_o);
        end
        checks++;
        if (ar_cnt_o !== 16'd0 || aw_cnt_o !== 16'd0) begin
            failures++; $display("FAIL reset_stats: got %0d %0d, want 0 0", ar_cnt_o, aw_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_zero_bytes();
        reset_obs();
        ready_mode = 0;
        start_go(32'h100, 32'h200, 32'd0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || dma_go_o !== 1'b0) begin
            failures++; $display("FAIL zero_done: got done=%0b busy=%0b go=%0b, want 1 0 0", done_o, busy_o, dma_go_o);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != 1 || ar_hs_cnt != 0 || aw_hs_cnt != 0 || go_cnt != 0) begin
            failures++;
            $display("FAIL zero_activity: got done=%0d ar=%0d aw=%0d go=%0d, want 1 0 0 0", done_cnt, ar_hs_cnt, aw_hs_cnt, go_cnt);
        end
    endtask

    task automatic test_outstanding();
        b_auto = 1'b0;
        b_valid_i = 1'b0;
        ready_mode = 0;
        repeat (2) begin
            @(posedge clk); #1 b_valid_i = 1'b1;
            @(posedge clk); #1 b_valid_i = 1'b0;
        end
        reset_obs();
        model_side(32'h10000, 8192, 0);
        model_side(32'h20000, 8192, 1);
        start_go(32'h10000, 32'h20000, 32'd8192);
        repeat (60) @(negedge clk);
        checks++;
        if (aw_hs_cnt != 4 || aw_valid_o !== 1'b0) begin
            failures++; $display("FAIL outst_stall: got aw_hs=%0d aw_valid=%0b, want 4 0", aw_hs_cnt, aw_valid_o);
        end
        checks++;
        if (ar_hs_cnt != 8 || busy_o !== 1'b1) begin
            failures++; $display("FAIL outst_reads: got ar_hs=%0d busy=%0b, want 8 1", ar_hs_cnt, busy_o);
        end
        for (int p = 0; p < 8; p++) begin
            @(posedge clk); #1 b_valid_i = 1'b1;
            @(posedge clk); #1 b_valid_i = 1'b0;
            repeat (4) @(negedge clk);
            if (p < 4) begin
                checks++;
                if (aw_hs_cnt != 5 + p) begin
                    failures++; $display("FAIL outst_resume%0d: got aw_hs=%0d, want %0d", p, aw_hs_cnt, 5 + p);
                end
            end
        end
        wait_done("outstanding", 200);
        repeat (2) @(negedge clk);
        compare_all("outstanding");
    endtask

    task automatic test_clear();
        reset_obs();
        b_auto = 1'b0;
        b_valid_i = 1'b0;
        ready_mode = 1;
        start_go(32'h0, 32'h8000, 32'd4096);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 clear_i = 1'b1;
        @(posedge clk); #1 clear_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || ar_valid_o !== 1'b0 || aw_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_state: got busy=%0b ar=%0b aw=%0b, want 0 0 0", busy_o, ar_valid_o, aw_valid_o);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt != 0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL clear_no_done: got done=%0d busy=%0b, want 0 0", done_cnt, busy_o);
        end
        pending_b = 0;
    endtask

    task automatic test_reset_midburst();
        reset_obs();
        b_auto = 1'b1;
        ready_mode = 0;
        start_go(32'h0, 32'h4000, 32'd2048);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        pending_b = 0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || ar_valid_o !== 1'b0 || aw_valid_o !== 1'b0 || dma_go_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got busy=%0b ar=%0b aw=%0b go=%0b, want 0 0 0 0", busy_o, ar_valid_o, aw_valid_o, dma_go_o);
        end
        @(posedge clk); #1 rst = 1'b0;
        pending_b = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_go_while_busy();
        reset_obs();
        ready_mode = 2;
        b_auto = 1'b1;
        model_side(32'h3000, 300, 0);
        model_side(32'h5000, 300, 1);
        start_go(32'h3000, 32'h5000, 32'd300);
        repeat (3) @(negedge clk);
        start_go(32'h7000, 32'h9000, 32'd64);
        repeat (3) @(negedge clk);
        checks++;
        if (dma_desc_o !== '{src_addr: 32'h3000, dst_addr: 32'h5000, num_bytes: 32'd300}) begin
            failures++; $display("FAIL busy_desc: got %h, want first descriptor", dma_desc_o);
        end
        ready_mode = 0;
        wait_done("go_while_busy", 500);
        repeat (2) @(negedge clk);
        compare_all("go_while_busy");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [31:0] s, d, n;
            s = 32'($urandom_range(0, 16383));
            d = 32'($urandom_range(16384, 32767));
            n = 32'($urandom_range(1, 3000));
            run_transfer($sformatf("rand%0d", t), s, d, n, 1);
        end
    endtask

    initial begin
        test_reset();
        run_transfer("aligned", 32'h1000, 32'h2000, 32'd128, 0);
        run_transfer("unaligned", 32'h1003, 32'h2010, 32'd100, 1);
        run_transfer("cross4k", 32'h0FC0, 32'h3000, 32'd256, 0);
        run_transfer("max_beats", 32'h0, 32'h8000, 32'd2048, 1);
        test_zero_bytes();
        test_outstanding();
        test_clear();
        run_transfer("after_clear", 32'h1000, 32'h2000, 32'd128, 0);
        test_reset_midburst();
        run_transfer("after_reset", 32'h0040, 32'h6001, 32'd700, 1);
        test_go_while_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
